// File: rtl/lsu_subword_if.sv
// ============================================================================
//  Module      : lsu_subword_if
//  Description : Request/response bundle between the core datapath and the
//                sub-word load/store unit (valid/ready request, one-cycle
//                response pulse).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lsu_subword_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Core side: issues requests, consumes responses
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/lsu_subword.sv
// ============================================================================
//  Module      : lsu_subword
//  Description : Load/store unit in front of a word-only dmem (sync write,
//                async read). Adds byte/half loads with sign/zero extension
//                and byte/half stores through read-modify-write.
//  Options     : MISALIGN_TRAP_EN - when defined, misaligned or out-of-range
//                accesses are rejected with rsp_err instead of being aligned
//                down / wrapped.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_subword #(
    parameter int MEM_BYTES = 256
) (
    input  wire logic        clk,
    input  wire logic        reset,
    lsu_subword_if.slave     bus,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  wire logic [31:0] mem_rd
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [31:0] C_ADDR_MASK = 32'(MEM_BYTES - 1);

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        w_trap;
    logic        w_mem_phase;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

`ifdef MISALIGN_TRAP_EN
    // Reject misaligned halves/words and anything beyond the memory size
    always_comb begin
        w_trap = 1'b0;
        if (bus.req_size == SZ_HALF && bus.req_addr[0])
            w_trap = 1'b1;
        if (bus.req_size[1] && bus.req_addr[1:0] != 2'b00)
            w_trap = 1'b1;
        if (bus.req_addr >= 32'(MEM_BYTES))
            w_trap = 1'b1;
    end
`else
    // No checking: low address bits are dropped and the address wraps
    assign w_trap = 1'b0;
`endif

    // Select the addressed lane of the read word and extend it
    always_comb begin
        w_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (size_q)
            SZ_BYTE: w_load_ext = uns_q ? {24'h000000, w_byte}
                                        : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load_ext = uns_q ? {16'h0000, w_half}
                                        : {{16{w_half[15]}}, w_half};
            default: w_load_ext = mem_rd;
        endcase
    end

    // Replace the addressed lane of the captured word with the store data
    always_comb begin
        w_merged = merge_q;
        case (size_q)
            SZ_BYTE: w_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: w_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: w_merged = wdata_q;
        endcase
    end

    // dmem drive: address only while an access is in flight, write only in WRITE
    assign w_mem_phase = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE);
    assign mem_a       = w_mem_phase ? ({addr_q[31:2], 2'b00} & C_ADDR_MASK) : 32'h0;
    assign mem_we      = (state_q == S_WRITE);
    assign mem_wd      = w_merged;

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Next-state and datapath capture for the access sequencer
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (w_trap) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!bus.req_we) begin
                        state_d = S_LOAD;
                    end else if (bus.req_size == SZ_BYTE || bus.req_size == SZ_HALF) begin
                        state_d = S_RMW_RD;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = w_load_ext;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                merge_d = mem_rd;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured request registers; reset aborts any access at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store flag is kept with the request for visibility; sequencing is decided at accept
    logic w_unused_ok;
    assign w_unused_ok = we_q;

endmodule

`default_nettype wire
